// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if
// Bundles the control/configuration inputs and the indicator outputs of
// clk_div_bank so the bank and its driver share one connection point.
//
// Signals:
//   en        global run; low freezes every channel
//   sync      restart all channels phase-aligned
//   load      write strobe for one channel's shadow configuration
//   ch_sel    channel addressed by load
//   div_val   half-period in cycles (0 = halted)
//   inv       output polarity for the addressed channel
//   led_out   divided outputs, one bit per channel
//   pulse_out one-cycle pulse after each toggle (only with CLK_DIV_BANK_PULSE_EN)
//
// Modports: master drives the controls, slave is the divider bank.
// Optional feature macro: CLK_DIV_BANK_PULSE_EN

interface clk_div_bank_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic                sync;
    logic                load;
    logic [SEL_W-1:0]    ch_sel;
    logic [DIV_W-1:0]    div_val;
    logic                inv;
    logic [CHANNELS-1:0] led_out;
`ifdef CLK_DIV_BANK_PULSE_EN
    logic [CHANNELS-1:0] pulse_out;

    modport master (
        output en, sync, load, ch_sel, div_val, inv,
        input  led_out, pulse_out
    );
    modport slave (
        input  en, sync, load, ch_sel, div_val, inv,
        output led_out, pulse_out
    );
`else
    modport master (
        output en, sync, load, ch_sel, div_val, inv,
        input  led_out
    );
    modport slave (
        input  en, sync, load, ch_sel, div_val, inv,
        output led_out
    );
`endif
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank
// Bank of independent clock dividers driving indicator outputs from the
// system clock. Each channel toggles its output every `div` enabled cycles,
// so the output period is 2*div cycles. New settings go into a per-channel
// shadow register and are only copied into the running configuration at a
// half-period boundary (or on sync / while halted), so an output never
// produces a short pulse when it is reprogrammed.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   bank_io  clk_div_bank_if.slave (controls in, led_out/pulse_out out)
//
// Optional feature macro: CLK_DIV_BANK_PULSE_EN adds pulse_out, a one-cycle
// pulse following every edge at which a channel's toggle flop changed.

module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    clk_div_bank_if.slave    bank_io
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [CHANNELS-1:0] ledVec;
`ifdef CLK_DIV_BANK_PULSE_EN
    logic [CHANNELS-1:0] pulseVec;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        logic [DIV_W-1:0] shDiv_q;
        logic             shInv_q;
        logic [DIV_W-1:0] div_q, div_d;
        logic             actInv_q, actInv_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic             tog_q, tog_d;
        logic             led_q;
        logic             loadHit;

        // Out-of-range channel selects simply match no channel.
        assign loadHit = bank_io.load
                      && (int'(bank_io.ch_sel) == g)
                      && (int'(bank_io.ch_sel) < CHANNELS);

        // Shadow configuration is writable regardless of en so software can
        // stage a new setting while the bank is frozen.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shDiv_q <= '0;
                shInv_q <= 1'b0;
            end else if (loadHit) begin
                shDiv_q <= bank_io.div_val;
                shInv_q <= bank_io.inv;
            end
        end

        // Next-state for the running divider. sync beats halt beats the
        // terminal count; every commit reads the shadow value from before
        // this edge, so a same-edge load waits for the next boundary.
        always_comb begin
            div_d    = div_q;
            actInv_d = actInv_q;
            cnt_d    = cnt_q;
            tog_d    = tog_q;
            if (bank_io.en) begin
                if (bank_io.sync || (div_q == '0)) begin
                    div_d    = shDiv_q;
                    actInv_d = shInv_q;
                    cnt_d    = '0;
                    tog_d    = 1'b0;
                end else if (cnt_q == (div_q - DIV_ONE)) begin
                    div_d    = shDiv_q;
                    actInv_d = shInv_q;
                    cnt_d    = '0;
                    tog_d    = (shDiv_q == '0) ? 1'b0 : ~tog_q;
                end else begin
                    cnt_d    = cnt_q + DIV_ONE;
                end
            end
        end

        // Running state plus a registered copy of the output so led_out
        // comes straight from a flop with no input-to-output path.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q    <= '0;
                actInv_q <= 1'b0;
                cnt_q    <= '0;
                tog_q    <= 1'b0;
                led_q    <= 1'b0;
            end else begin
                div_q    <= div_d;
                actInv_q <= actInv_d;
                cnt_q    <= cnt_d;
                tog_q    <= tog_d;
                led_q    <= tog_d ^ actInv_d;
            end
        end

        assign ledVec[g] = led_q;

`ifdef CLK_DIV_BANK_PULSE_EN
        logic pulse_q;

        // A toggle change of either direction (including a forced clear by
        // sync or halt) yields one cycle of pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= (tog_d != tog_q);
            end
        end

        assign pulseVec[g] = pulse_q;
`endif
    end

    assign bank_io.led_out = ledVec;
`ifdef CLK_DIV_BANK_PULSE_EN
    assign bank_io.pulse_out = pulseVec;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
// Self-checking bench for clk_div_bank: directed vector tables for the
// documented timing sequences, plus randomized traffic compared every cycle
// against a behavioural model of the channel rules.
// Optional feature macro: CLK_DIV_BANK_PULSE_EN (pulse_out checks).

module tb_clk_div_bank;

    localparam int CH = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;

    clk_div_bank_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

    clk_div_bank #(.CHANNELS(CH), .DIV_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bank_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          sync;
        bit          load;
        int          sel;
        int          div;
        bit          inv;
        bit          chk;
        logic [CH-1:0] expLed;
    } vec_t;

    vec_t vecs[$];

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model: each channel remembers how many enabled cycles
    // have elapsed since its configuration was last committed.
    int mShDiv[CH];
    int mShInv[CH];
    int mDiv[CH];
    int mInv[CH];
    int mElapsed[CH];
    int mTog[CH];
    int mPulse[CH];

    function automatic void modelReset();
        for (int c = 0; c < CH; c++) begin
            mShDiv[c] = 0; mShInv[c] = 0; mDiv[c] = 0; mInv[c] = 0;
            mElapsed[c] = 0; mTog[c] = 0; mPulse[c] = 0;
        end
    endfunction

    function automatic void modelStep(bit en, bit sync, bit load, int sel, int div, bit inv);
        for (int c = 0; c < CH; c++) begin
            int  oldTog;
            bit  commit;
            oldTog    = mTog[c];
            commit    = 1'b0;
            mPulse[c] = 0;
            if (en) begin
                if (sync || mDiv[c] == 0) begin
                    commit  = 1'b1;
                    mTog[c] = 0;
                end else if (mElapsed[c] + 1 == mDiv[c]) begin
                    commit  = 1'b1;
                    mTog[c] = (mShDiv[c] == 0) ? 0 : 1 - mTog[c];
                end else begin
                    mElapsed[c]++;
                end
                if (commit) begin
                    mDiv[c]     = mShDiv[c];
                    mInv[c]     = mShInv[c];
                    mElapsed[c] = 0;
                end
                mPulse[c] = (mTog[c] != oldTog) ? 1 : 0;
            end
        end
        if (load && sel < CH) begin
            mShDiv[sel] = div;
            mShInv[sel] = inv;
        end
    endfunction

    function automatic logic [CH-1:0] modelLed();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = 1'((mTog[c] ^ mInv[c]) & 1);
        return r;
    endfunction

    function automatic logic [CH-1:0] modelPulse();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = (mPulse[c] != 0);
        return r;
    endfunction

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // compare shortly after the edge.
    task automatic applyStimulus(bit en, bit sync, bit load, int sel, int div, bit inv, string name);
        bus.en      = en;
        bus.sync    = sync;
        bus.load    = load;
        bus.ch_sel  = 2'(sel);
        bus.div_val = 8'(div);
        bus.inv     = inv;
        @(posedge clk);
        modelStep(en, sync, load, sel, div, inv);
        #1;
        checkOutput({name, " led model"}, 32'(bus.led_out), 32'(modelLed()));
`ifdef CLK_DIV_BANK_PULSE_EN
        checkOutput({name, " pulse model"}, 32'(bus.pulse_out), 32'(modelPulse()));
`endif
    endtask

    function automatic void addVec(bit en, bit sync, bit load, int sel, int div, bit inv,
                                   bit chk, logic [CH-1:0] expLed);
        vec_t v;
        v.en = en; v.sync = sync; v.load = load; v.sel = sel; v.div = div;
        v.inv = inv; v.chk = chk; v.expLed = expLed;
        vecs.push_back(v);
    endfunction

    function automatic void addIdle(int n, logic [CH-1:0] expLed);
        for (int i = 0; i < n; i++) addVec(1, 0, 0, 0, 0, 0, 1, expLed);
    endfunction

    task automatic runVecs(string name);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].sync, vecs[i].load, vecs[i].sel,
                          vecs[i].div, vecs[i].inv, $sformatf("%s[%0d]", name, i));
            if (vecs[i].chk)
                checkOutput($sformatf("%s[%0d] led", name, i), 32'(bus.led_out), 32'(vecs[i].expLed));
        end
        vecs.delete();
    endtask

    // Asserts reset between edges and checks that outputs clear at once.
    task automatic hardReset(string name);
        bus.en = 0; bus.sync = 0; bus.load = 0; bus.ch_sel = '0; bus.div_val = '0; bus.inv = 0;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput({name, " led"}, 32'(bus.led_out), 32'h0);
`ifdef CLK_DIV_BANK_PULSE_EN
        checkOutput({name, " pulse"}, 32'(bus.pulse_out), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        #2;
        hardReset("initial reset");

        // Idle with en=1, then ch0 div=3 sequence, then a sync restart.
        addIdle(20, 4'b0000);
        addVec(1, 0, 1, 0, 3, 0, 1, 4'b0000);
        addIdle(3, 4'b0000);
        addIdle(3, 4'b0001);
        addIdle(3, 4'b0000);
        addIdle(1, 4'b0001);
        addVec(1, 1, 0, 0, 0, 0, 1, 4'b0000);
        addIdle(2, 4'b0000);
        addIdle(1, 4'b0001);
        runVecs("ch0div3");

        // Ch1 div=2 reprogrammed to 5 mid half-period.
        hardReset("reset ch1");
        addVec(1, 0, 1, 1, 2, 0, 1, 4'b0000);
        addIdle(2, 4'b0000);
        addIdle(1, 4'b0010);
        addVec(1, 0, 1, 1, 5, 0, 1, 4'b0010);
        addIdle(5, 4'b0000);
        addIdle(5, 4'b0010);
        addIdle(1, 4'b0000);
        runVecs("ch1reload");

        // Ch0 and ch2 at div=3 but out of phase, then aligned by sync.
        hardReset("reset sync");
        addVec(1, 0, 1, 0, 3, 0, 1, 4'b0000);
        addIdle(1, 4'b0000);
        addVec(1, 0, 1, 2, 3, 0, 1, 4'b0000);
        addIdle(1, 4'b0000);
        addIdle(2, 4'b0001);
        addIdle(1, 4'b0101);
        addIdle(1, 4'b0100);
        addVec(1, 1, 0, 0, 0, 0, 1, 4'b0000);
        addIdle(2, 4'b0000);
        addIdle(1, 4'b0101);
        runVecs("sync");

        // Freeze for 7 cycles with a ch3 load staged during the freeze.
        hardReset("reset freeze");
        addVec(1, 0, 1, 0, 3, 0, 1, 4'b0000);
        addIdle(3, 4'b0000);
        addIdle(1, 4'b0001);
        for (int i = 0; i < 7; i++)
            addVec(0, (i == 4), (i == 2), 3, 0, 1, 1, 4'b0001);
        addIdle(2, 4'b1001);
        addIdle(1, 4'b1000);
        runVecs("freeze");

        // Mid-operation reset clears the running outputs immediately.
        hardReset("midrun reset");

`ifdef CLK_DIV_BANK_PULSE_EN
        begin
            int pulses;
            pulses = 0;
            applyStimulus(1, 0, 1, 0, 2, 0, "pulse load");
            for (int i = 0; i < 9; i++) begin
                applyStimulus(1, 0, 0, 0, 0, 0, "pulse run");
                if (bus.pulse_out[0]) pulses++;
            end
            checkOutput("pulse count", 32'(pulses), 32'd4);
            checkOutput("pulse high before reset", 32'(bus.pulse_out[0]), 32'd1);
            hardReset("pulse reset");
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                          $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), d,
                          1'($urandom_range(0, 1)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
